// File: rtl/latch_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : latch_response_checker
// Description : Clocked monitor for a D latch with reset. Synchronizes the
//               latch stimulus and response, runs a golden latch model and
//               compares q/qb against it once the stimulus has been quiet for
//               SETTLE cycles. Counts compares and failures (saturating),
//               pulses mismatch and holds a sticky fail flag.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_response_checker #(
  parameter int SETTLE = 2,   // quiet cycles before a compare, 1..15
  parameter int CNT_W  = 8    // counter width
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             g,
  input  logic             lrst,
  input  logic             q,
  input  logic             qb,
  output logic [CNT_W-1:0] cmp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mismatch,
  output logic             fail,
  output logic             busy
);

  localparam logic [3:0]       c_SETTLE_LD = 4'(SETTLE);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Synchronizer stages, packed as {d, g, lrst, q, qb}
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;

  logic       w_d_s, w_g_s, w_lrst_s, w_q_s, w_qb_s;
  logic [2:0] w_tup;
  logic [2:0] r_tup_p;
  logic       w_change;
  logic       r_exp_q;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt;   // tuple moved during the CHECK cycle
  logic       w_check;
  logic       w_bad;

  assign w_d_s    = r_sync2[4];
  assign w_g_s    = r_sync2[3];
  assign w_lrst_s = r_sync2[2];
  assign w_q_s    = r_sync2[1];
  assign w_qb_s   = r_sync2[0];
  assign w_tup    = {w_d_s, w_g_s, w_lrst_s};
  assign w_change = (w_tup != r_tup_p);

  assign w_check  = (r_state == ST_CHECK);
  assign w_bad    = (w_q_s != r_exp_q) || (w_qb_s == w_q_s);
  assign busy     = (r_state != ST_IDLE);

  // Two-flop synchronizers, previous-tuple register and golden latch model
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_tup_p <= '0;
      r_exp_q <= 1'b0;
    end else begin
      r_sync1 <= {d, g, lrst, q, qb};
      r_sync2 <= r_sync1;
      r_tup_p <= w_tup;
      // latch reset dominates the gate; otherwise transparent while gate high
      if (w_lrst_s)
        r_exp_q <= 1'b0;
      else if (w_g_s)
        r_exp_q <= w_d_s;
    end
  end

  // FSM state, settle counter and pending-change register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= c_SETTLE_LD;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next-state logic: settle window, single-cycle compare, hold until change
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = c_SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (w_change)
          w_cnt_nxt = c_SETTLE_LD;
        else if (r_cnt <= 4'd1)
          w_state_nxt = ST_CHECK;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      ST_CHECK: begin
        // a change in this cycle does not affect the compare, but must
        // still force a fresh settle window after HOLD
        w_state_nxt = ST_HOLD;
        w_pend_nxt  = w_change;
      end
      ST_HOLD: begin
        if (w_change || r_pend) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = c_SETTLE_LD;
          w_pend_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (clr) begin
      w_state_nxt = en ? ST_SETTLE : ST_IDLE;
      w_cnt_nxt   = c_SETTLE_LD;
      w_pend_nxt  = 1'b0;
    end else if (!en) begin
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = 1'b0;
    end
  end

  // Compare result bookkeeping: saturating counters, mismatch pulse, sticky fail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_cnt  <= '0;
      err_cnt  <= '0;
      mismatch <= 1'b0;
      fail     <= 1'b0;
    end else if (clr) begin
      cmp_cnt  <= '0;
      err_cnt  <= '0;
      mismatch <= 1'b0;
      fail     <= 1'b0;
    end else if (w_check) begin
      if (cmp_cnt != c_CNT_MAX)
        cmp_cnt <= cmp_cnt + c_CNT_ONE;
      if (w_bad && (err_cnt != c_CNT_MAX))
        err_cnt <= err_cnt + c_CNT_ONE;
      mismatch <= w_bad;
      fail     <= fail | w_bad;
    end else begin
      mismatch <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_response_checker
// Description : Directed bench for latch_response_checker (SETTLE=2, CNT_W=4).
//               A cycle-level behavioural model predicts every output each
//               cycle; directed scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_response_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 4;
  localparam int MAX    = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, clr = 1'b0;
  logic d = 1'b0, g = 1'b0, lrst = 1'b0, q = 1'b0, qb = 1'b0;
  logic [CNT_W-1:0] cmp_cnt, err_cnt;
  logic mismatch, fail, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // observation records
  int mis_pulses = 0;
  int last_mis_rise = -1;
  int last_cmp_edge = -1;

  latch_response_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .d(d), .g(g), .lrst(lrst), .q(q), .qb(qb),
    .cmp_cnt(cmp_cnt), .err_cnt(err_cnt),
    .mismatch(mismatch), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a compare happens in the cycle after the synchronized
  // stimulus has been quiet for SETTLE enabled cycles, at most once per steady
  // state. busy simply follows en one cycle late.
  initial begin : model_and_compare
    bit [4:0] m_s1, m_s;          // {d,g,lrst,q,qb}
    bit [2:0] m_tup_prev, tup;
    bit m_exp, m_busy, m_check, m_done, m_defer, m_mis, m_fail;
    bit ch, rq, decide, bad, prev_mis;
    int m_quiet, quiet, m_cmp, m_err, prev_cmp;
    m_s1 = '0; m_s = '0; m_tup_prev = '0; m_exp = 0; m_busy = 0;
    m_check = 0; m_done = 0; m_defer = 0; m_mis = 0; m_fail = 0;
    m_quiet = 0; m_cmp = 0; m_err = 0; prev_mis = 0; prev_cmp = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_s1 = '0; m_s = '0; m_tup_prev = '0; m_exp = 0; m_busy = 0;
        m_check = 0; m_done = 0; m_defer = 0; m_mis = 0; m_fail = 0;
        m_quiet = 0; m_cmp = 0; m_err = 0;
      end else begin
        tup    = m_s[4:2];
        ch     = (tup != m_tup_prev);
        rq     = !m_busy || (ch && !m_check) || clr || m_defer;
        quiet  = rq ? 0 : m_quiet + 1;
        decide = m_busy && en && !clr && !m_done && !m_check && (quiet == SETTLE);
        bad    = (m_s[1] != m_exp) || (m_s[0] == m_s[1]);
        if (clr) begin
          m_cmp = 0; m_err = 0; m_mis = 0; m_fail = 0;
        end else if (m_check) begin
          if (m_cmp < MAX) m_cmp++;
          if (bad && m_err < MAX) m_err++;
          m_mis  = bad;
          m_fail = m_fail | bad;
        end else begin
          m_mis = 0;
        end
        m_done  = clr ? 1'b0 : (m_check ? 1'b1 : (rq ? 1'b0 : m_done));
        m_defer = m_check && ch && !clr;
        m_check = decide;
        m_quiet = quiet;
        m_busy  = en;
        if (m_s[2]) m_exp = 1'b0;
        else if (m_s[3]) m_exp = m_s[4];
        m_tup_prev = tup;
        m_s  = m_s1;
        m_s1 = {d, g, lrst, q, qb};
      end
      #1;
      if (rst) begin
        chk("cmp_cnt", int'(cmp_cnt), m_cmp);
        chk("err_cnt", int'(err_cnt), m_err);
        chk("mismatch", int'(mismatch), int'(m_mis));
        chk("fail", int'(fail), int'(m_fail));
        chk("busy", int'(busy), int'(m_busy));
      end
      if (mismatch && !prev_mis) begin
        mis_pulses++;
        last_mis_rise = cyc;
      end
      if (int'(cmp_cnt) != prev_cmp) last_cmp_edge = cyc;
      prev_mis = mismatch;
      prev_cmp = int'(cmp_cnt);
    end
  end

  // Directed scenarios
  initial begin : stimulus
    int n, mp0;
    // reset state
    nc(3);
    chk("rst_cmp", int'(cmp_cnt), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    nc(3);
    chk("idle_busy", int'(busy), 0);

    // correct latch, gate open, d toggled five times
    g = 1; d = 0; q = 0; qb = 1; en = 1;
    nc(20);
    for (int i = 0; i < 5; i++) begin
      d = ~d; q = d; qb = ~d;
      nc(20);
    end
    chk("t1_cmp", int'(cmp_cnt), 6);
    chk("t1_err", int'(err_cnt), 0);
    chk("t1_fail", int'(fail), 0);
    chk("t1_mis_pulses", mis_pulses, 0);

    // q stuck at 0 with d=1
    clr = 1; d = 0; q = 0; qb = 1;
    nc(1);
    clr = 0;
    nc(20);
    chk("t2_pass_cmp", int'(cmp_cnt), 1);
    mp0 = mis_pulses;
    d = 1; n = cyc + 1;
    nc(20);
    chk("t2_cmp", int'(cmp_cnt), 2);
    chk("t2_err", int'(err_cnt), 1);
    chk("t2_fail", int'(fail), 1);
    chk("t2_mis_pulses", mis_pulses - mp0, 1);
    chk("t2_mis_edge", last_mis_rise, n + 5);
    nc(20);
    chk("t2_fail_sticky", int'(fail), 1);
    chk("t2_err_hold", int'(err_cnt), 1);

    // d toggling every cycle, then stable
    for (int i = 0; i < 10; i++) begin
      d = ~d; q = d; qb = ~d;
      clr = (i == 0);
      if (i == 9) n = cyc + 1;
      nc(1);
    end
    clr = 0;
    nc(20);
    chk("t3_cmp", int'(cmp_cnt), 1);
    chk("t3_err", int'(err_cnt), 0);
    chk("t3_fail", int'(fail), 0);
    chk("t3_cmp_edge", last_cmp_edge, n + 5);

    // latch reset dominates gate, then qb collapses
    clr = 1; lrst = 1; g = 1; d = 1; q = 0; qb = 1;
    nc(1);
    clr = 0;
    nc(20);
    chk("t4_pass_cmp", int'(cmp_cnt), 1);
    chk("t4_pass_err", int'(err_cnt), 0);
    qb = 0;
    nc(5);
    en = 0;
    nc(3);
    en = 1;
    nc(20);
    chk("t4_cmp", int'(cmp_cnt), 2);
    chk("t4_err", int'(err_cnt), 1);
    chk("t4_fail", int'(fail), 1);

    // saturation: q and qb both high, every compare fails
    lrst = 0; clr = 1; q = 1; qb = 1; d = 0;
    nc(1);
    clr = 0;
    nc(10);
    for (int i = 0; i < 20; i++) begin
      d = ~d;
      nc(8);
    end
    chk("t5_err_sat", int'(err_cnt), 15);
    chk("t5_cmp_sat", int'(cmp_cnt), 15);
    chk("t5_fail", int'(fail), 1);
    clr = 1;
    nc(1);
    clr = 0;
    chk("t5_clr_cmp", int'(cmp_cnt), 0);
    chk("t5_clr_err", int'(err_cnt), 0);
    chk("t5_clr_fail", int'(fail), 0);
    chk("t5_clr_mis", int'(mismatch), 0);

    // async reset in the middle of a settle window
    nc(10);
    for (int i = 0; i < 2; i++) begin
      d = ~d;
      nc(8);
    end
    chk("t6_err3", int'(err_cnt), 3);
    d = ~d;
    nc(3);
    chk("t6_busy_pre", int'(busy), 1);
    rst = 0;
    #1;
    chk("t6_rst_cmp", int'(cmp_cnt), 0);
    chk("t6_rst_err", int'(err_cnt), 0);
    chk("t6_rst_fail", int'(fail), 0);
    chk("t6_rst_mis", int'(mismatch), 0);
    chk("t6_rst_busy", int'(busy), 0);
    en = 0;
    nc(3);
    rst = 1;
    nc(10);
    chk("t6_idle_cmp", int'(cmp_cnt), 0);
    chk("t6_idle_busy", int'(busy), 0);
    en = 1;
    nc(20);
    chk("t6_resume_cmp", int'(cmp_cnt), 1);
    chk("t6_resume_err", int'(err_cnt), 1);
    chk("t6_resume_busy", int'(busy), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/latch_response_checker.md
Name: latch_response_checker

Overview:
- Synthesizable monitor that sits at the output end of a clocked D latch with reset.
- It observes the latch's stimulus (d, gate, latch reset) and its outputs (q, qb).
- It runs its own golden model of the latch and compares q/qb against that model once the inputs have been stable for a settle window.
- It counts compares and mismatches and raises a sticky fail flag, giving hardware self-check of latch designs on board or in regression.

Parameters:
- SETTLE, 2, sys-clk cycles the synchronized {d,g,lrst} tuple must be unchanged before a compare (legal range 1..15)
- CNT_W, 8, width of the compare and error counters

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  checking enable; level-sensitive
- clr  input  1  synchronous clear of counters and fail; higher priority than en
- d  input  1  latch data input as driven to the DUT (asynchronous to clk)
- g  input  1  latch gate (DUT clk) as driven to the DUT (asynchronous)
- lrst  input  1  DUT latch reset, active-high (asynchronous)
- q  input  1  DUT Q output (asynchronous)
- qb  input  1  DUT Qb output (asynchronous)
- cmp_cnt  output  CNT_W  number of compares performed, saturating
- err_cnt  output  CNT_W  number of failed compares, saturating
- mismatch  output  1  one-cycle pulse per failed compare
- fail  output  1  sticky: at least one failed compare since reset/clr
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=0, async): FSM=IDLE; cmp_cnt=0, err_cnt=0, mismatch=0, fail=0, busy=0; settle counter=SETTLE; synchronizer flops and model exp_q=0.
- Input sync: d, g, lrst, q, qb each pass through a 2-flop synchronizer. All logic below uses the synchronized values (suffix _s).
- Golden model, updated every cycle regardless of FSM:
  - lrst_s=1 -> exp_q=0
  - else g_s=1 -> exp_q=d_s
  - else hold
  - Reset dominates gate.
- Stability: tup = {d_s,g_s,lrst_s}, registered as tup_p. A change occurs when tup != tup_p.
- FSM states: IDLE, SETTLE, CHECK, HOLD.
- IDLE: en=1 -> SETTLE, settle counter loaded with SETTLE.
- SETTLE:
  - change -> reload counter, stay.
  - Else decrement; when counter reaches 1 and no change -> CHECK.
- CHECK (exactly one cycle):
  - Compare fails if q_s != exp_q or qb_s != ~q_s.
  - cmp_cnt+1 on every compare; err_cnt+1 on failure; both saturate at 2^CNT_W-1.
  - Next -> HOLD.
- HOLD: no further compares of the same steady state; change -> SETTLE (counter reloaded).
- en=0 in any state -> IDLE next cycle. Counters and fail are held, not cleared. A CHECK cycle coinciding with en falling still completes its compare.
- Outputs on a failed compare:
  - mismatch registered: high for the one cycle following CHECK.
  - fail set on that same edge and held.
- clr=1: cmp_cnt=0, err_cnt=0, fail=0, mismatch=0 next edge; FSM -> SETTLE if en=1, else IDLE. clr wins over a simultaneous CHECK increment.
- Latency (SETTLE=2): input edge sampled at clk edge n; _s visible at n+2; CHECK at n+4; cmp_cnt/err_cnt/mismatch update at edge n+5.
- Glitch rule: a tuple change during SETTLE never produces a compare; a change in the CHECK cycle is ignored for that compare and triggers SETTLE via HOLD.
- Mid-operation rst: async return to reset values; no partial count survives.

Test Plan:
- Correct latch, g=1, d toggling every 20 clk cycles, 5 toggles, en=1, SETTLE=2 -> cmp_cnt=6 (initial + 5), err_cnt=0, fail=0, mismatch never high.
- q stuck at 0 while g=1, d=1 held -> exactly one compare; err_cnt=1; mismatch high one cycle at edge n+5; fail=1 and stays 1.
- d toggling every 1 clk cycle for 10 cycles, then stable -> no compare during toggling; exactly one compare 4 cycles after last change; cmp_cnt=1.
- lrst=1 with g=1, d=1, DUT q=0, qb=1 -> pass; then DUT drives qb=0 (q=0) -> err_cnt=1, fail=1.
- Saturation with CNT_W=4: force 20 failed compares -> err_cnt=15, cmp_cnt=15; then clr=1 one cycle -> all 0, fail=0.
- Assert rst low mid-SETTLE after err_cnt=3 -> all outputs 0 immediately (async); busy=0; checking resumes only after rst=1 and en=1.
